fetch_ctrl: RTL

//   Instruction-fetch sequencer for the byte-addressed, big-endian, combinational instruction ROM.

---
 rtl/fetch_ctrl.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch sequencer for a combinational, byte-addressed ROM.
//   Owns the fetch PC, drives the ROM address, and captures each returned word
//   together with its PC into a 2-entry queue. The queue head goes to decode
//   through a valid/ready handshake. Redirects flush the queue and refetch, and
//   halt suspends fetching while the queue drains.
//
// Optional feature: define FETCH_BOUND_CHECK_EN to refuse fetches with
//   fetch_pc+3 >= ROM_BYTES. A refused fetch enters a sticky FAULT state, which is
//   left only by reset or by a redirect to an in-range target.
//
// Ports:
//   clk, rst      clock (rising edge) and asynchronous active-high reset
//   imem_addr     ROM byte address, equal to fetch_pc (combinational)
//   imem_data     ROM word at imem_addr, valid in the same cycle
//   inst_o, pc_o  queue head instruction and its PC; both 0 when inst_valid=0
//   inst_valid    queue head valid
//   inst_ready    decode accepts the head
//   redirect      load redirect_pc (word aligned) and flush the queue
//   redirect_pc   redirect target
//   halt          suspend fetching
//   fetch_fault   sticky out-of-range flag (tied 0 without FETCH_BOUND_CHECK_EN)
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned ROM_BYTES = 72
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    output logic [31:0] inst_o,
    output logic [31:0] pc_o,
    output logic        inst_valid,
    input  logic        inst_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    output logic        fetch_fault
);

    localparam int unsigned XLEN  = 32;
    localparam int unsigned DEPTH = 2;
    localparam int unsigned CNT_W = 2;
    localparam logic [XLEN:0] ROM_LIMIT = (XLEN+1)'(ROM_BYTES);

`ifdef FETCH_BOUND_CHECK_EN
    localparam logic BOUND_EN = 1'b1;
`else
    localparam logic BOUND_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FAULT = 2'd2
    } state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } entry_t;

    state_t            state_q, state_d;
    logic [XLEN-1:0]   fetch_pc_q, fetch_pc_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic              wr_ptr_q, wr_ptr_d;
    entry_t            queue_q [DEPTH];

    logic              push_c;
    logic              pop_c;
    logic [XLEN-1:0]   target_c;
    logic              pc_ok_c;
    logic              target_ok_c;

    // Redirect targets are forced to word alignment.
    assign target_c = {redirect_pc[XLEN-1:2], 2'b00};

    // 33-bit compare so the +3 cannot wrap near the top of the address space.
    assign pc_ok_c     = !BOUND_EN || (((XLEN+1)'(fetch_pc_q) + (XLEN+1)'(3)) < ROM_LIMIT);
    assign target_ok_c = !BOUND_EN || (((XLEN+1)'(target_c)   + (XLEN+1)'(3)) < ROM_LIMIT);

    assign inst_valid = (count_q != CNT_W'(0));
    assign pop_c      = inst_valid && inst_ready;
    assign imem_addr  = fetch_pc_q;
    assign inst_o     = inst_valid ? queue_q[rd_ptr_q].inst : '0;
    assign pc_o       = inst_valid ? queue_q[rd_ptr_q].pc   : '0;

`ifdef FETCH_BOUND_CHECK_EN
    // FAULT is only ever entered via a failed check and left via reset or a good redirect.
    assign fetch_fault = (state_q == FAULT);
`else
    assign fetch_fault = 1'b0;
`endif

    // State, PC and queue bookkeeping registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= RUN;
            fetch_pc_q <= {RESET_PC[XLEN-1:2], 2'b00};
            count_q    <= '0;
            rd_ptr_q   <= 1'b0;
            wr_ptr_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
        end
    end

    // Queue storage; a push into a full queue overwrites the slot being popped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                queue_q[i] <= '0;
            end
        end else if (push_c) begin
            queue_q[wr_ptr_q] <= '{pc: fetch_pc_q, inst: imem_data};
        end
    end

    // Next-state: redirect > fault > halt > normal fetch.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        count_d    = count_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        push_c     = 1'b0;

        if (redirect) begin
            fetch_pc_d = target_c;
            count_d    = '0;
            rd_ptr_d   = 1'b0;
            wr_ptr_d   = 1'b0;
            if (!target_ok_c) begin
                state_d = FAULT;
            end else if (halt) begin
                state_d = STALL;
            end else begin
                state_d = RUN;
            end
        end else begin
            unique case (state_q)
                RUN: begin
                    if (!pc_ok_c) begin
                        state_d = FAULT;
                    end else if (halt) begin
                        state_d = STALL;
                    end else if ((count_q < CNT_W'(DEPTH)) || pop_c) begin
                        push_c = 1'b1;
                    end
                end
                STALL: begin
                    if (!halt) begin
                        state_d = RUN;
                    end
                end
                FAULT: begin
                    state_d = FAULT;
                end
                default: begin
                    state_d = RUN;
                end
            endcase

            if (push_c) begin
                fetch_pc_d = fetch_pc_q + XLEN'(4);
                wr_ptr_d   = ~wr_ptr_q;
            end
            if (pop_c) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            count_d = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
        end
    end

endmodule
